// File: rtl/eq_bus_clock_gen.sv
// Quadrature E/Q bus clock generator for a 6809-style bus, with wait-state stretch.
// Optional stretch timeout is enabled by defining STRETCH_TIMEOUT_EN.
module eq_bus_clock_gen #(
    parameter int unsigned WAIT_STATES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic CLK,
    input  logic RST,
    input  logic SLOW_CS,
    input  logic MRDY,
    output logic E,
    output logic Q,
    output logic CYCLE_END,
    output logic STRETCHED,
    output logic TIMEOUT
);

    typedef enum logic [2:0] {
        PH0,
        PH1,
        PH2,
        PH3,
        STRETCH
    } state_e;

    localparam logic [3:0] WS4 = 4'(WAIT_STATES);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       e_q, q_q, ce_q, st_q;
    logic       exit_ok;

`ifdef STRETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TC = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          to_q, to_d;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        exit_ok = (wait_q == 4'd0) && MRDY;
`ifdef STRETCH_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            PH0: state_d = PH1;
            PH1: state_d = PH2;
            PH2: begin
                state_d = PH3;
                wait_d  = SLOW_CS ? 4'd0 : WS4;
`ifdef STRETCH_TIMEOUT_EN
                tcnt_d  = '0;
`endif
            end
            PH3, STRETCH: begin
                if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
                state_d = exit_ok ? PH0 : STRETCH;
`ifdef STRETCH_TIMEOUT_EN
                // Forced exit only when the normal rule would keep stretching
                if (state_q == STRETCH) begin
                    tcnt_d = tcnt_q + 1'b1;
                    if (!exit_ok && tcnt_d == TC) begin
                        state_d = PH0;
                        wait_d  = 4'd0;
                        to_d    = 1'b1;
                    end
                end
`endif
            end
            default: state_d = PH0;
        endcase
    end

    // Outputs are registered copies of the decode of the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= PH0;
            wait_q  <= 4'd0;
            e_q     <= 1'b0;
            q_q     <= 1'b0;
            ce_q    <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            e_q     <= (state_d == PH2) || (state_d == PH3) || (state_d == STRETCH);
            q_q     <= (state_d == PH1) || (state_d == PH2);
            ce_q    <= (state_d == PH0);
            st_q    <= (state_d == STRETCH);
        end
    end

`ifdef STRETCH_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            to_q   <= to_d;
        end
    end

    assign TIMEOUT = to_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign E         = e_q;
    assign Q         = q_q;
    assign CYCLE_END = ce_q;
    assign STRETCHED = st_q;

endmodule

// File: tb/tb_eq_bus_clock_gen.sv
// Self-checking bench for eq_bus_clock_gen: directed and random SLOW_CS/MRDY
// against a cycle-position reference model.
module tb_eq_bus_clock_gen;

    localparam int WS = 2;
    localparam int TC = 40;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic SLOW_CS = 1'b1;
    logic MRDY = 1'b1;
    logic E, Q, CYCLE_END, STRETCHED, TIMEOUT;

    int vecs = 0;
    int bad  = 0;

    // Model: t = CLKs elapsed since the bus cycle began in PH0
    int t     = 0;
    int waits = 0;
    bit fresh = 1'b1;
    bit to_exp = 1'b0;
    bit in_rst = 1'b1;

    eq_bus_clock_gen #(
        .WAIT_STATES   (WS),
        .TIMEOUT_CYCLES(TC)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SLOW_CS  (SLOW_CS),
        .MRDY     (MRDY),
        .E        (E),
        .Q        (Q),
        .CYCLE_END(CYCLE_END),
        .STRETCHED(STRETCHED),
        .TIMEOUT  (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4:0] model_vec();
        logic [4:0] v;
        if (in_rst) return 5'b0;
        v[4] = (t >= 2);
        v[3] = (t == 1) || (t == 2);
        v[2] = (t == 0) && !fresh;
        v[1] = (t >= 4);
        v[0] = to_exp;
        return v;
    endfunction

    function automatic void model_adv(bit s, bit m);
        bit ten;
`ifdef STRETCH_TIMEOUT_EN
        ten = 1'b1;
`else
        ten = 1'b0;
`endif
        fresh  = 1'b0;
        to_exp = 1'b0;
        if (t == 2) waits = s ? 0 : WS;
        if (t >= 3) begin
            if ((t - 3) >= waits && m) t = 0;
            else if (ten && t >= 4 && (t - 3) == TC) begin
                t = 0;
                to_exp = 1'b1;
            end else t++;
        end else t++;
    endfunction

    task automatic chk(input string tag);
        logic [4:0] obs, exp;
        obs = {E, Q, CYCLE_END, STRETCHED, TIMEOUT};
        exp = model_vec();
        vecs++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d: got EQ/CE/ST/TO=%b want %b", tag, t, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit s, input bit m);
        @(negedge CLK);
        chk(tag);
        SLOW_CS = s;
        MRDY    = m;
        model_adv(s, m);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST    = 1'b1;
        in_rst = 1'b1;
        #1;
        chk({tag, "_async"});
        @(negedge CLK);
        chk({tag, "_held"});
        RST    = 1'b0;
        in_rst = 1'b0;
        t      = 0;
        waits  = 0;
        fresh  = 1'b1;
        to_exp = 1'b0;
        chk({tag, "_release"});
        SLOW_CS = 1'b1;
        MRDY    = 1'b1;
        model_adv(1'b1, 1'b1);
    endtask

    initial begin
        int ehigh;
        do_reset("rst0");

        for (int i = 0; i < 12; i++) step("nominal", 1'b1, 1'b1);

        for (int i = 0; i < 6; i++) step("slowcs", 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step("slow_after", 1'b1, 1'b1);

        // Align so MRDY goes low starting in PH3
        while (t != 2) step("align", 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step("mrdy3", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step("mrdy3_after", 1'b1, 1'b1);

        while (t != 1) step("align", 1'b1, 1'b1);
        step("both1_ph2", 1'b0, 1'b1);
        step("both1_ph3", 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step("both1_after", 1'b1, 1'b1);

        while (t != 1) step("align", 1'b1, 1'b1);
        step("both5_ph2", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("both5", 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step("both5_after", 1'b1, 1'b1);

        // Long MRDY low: times out with the option, stays stretched without it
        ehigh = 0;
        for (int i = 0; i < 50; i++) begin
            step("long_low", 1'b1, 1'b0);
            if (E) ehigh++;
        end
        for (int i = 0; i < 8; i++) step("long_after", 1'b1, 1'b1);
`ifndef STRETCH_TIMEOUT_EN
        vecs++;
        assert (ehigh >= 48) else begin
            bad++;
            $error("FAIL long_ehigh: got %0d want >=48", ehigh);
        end
`endif

        // Reset in the middle of a wait-state stretch
        while (t != 1) step("align", 1'b1, 1'b1);
        step("rst_mid_ph2", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("rst_mid", 1'b1, 1'b0);
        do_reset("rst_stretch");
        for (int i = 0; i < 10; i++) step("post_rst", 1'b1, 1'b1);

        for (int i = 0; i < 400; i++)
            step("random", 1'($urandom_range(0, 1)), ($urandom % 4) != 0);

        step("final", 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
